// File: rtl/noc_pkg.sv
// noc_pkg: shared constants for the mesh router node.
//   - port count and flit field widths used by the router node blocks
//   - scheduler FSM state encoding
//   - debug view of the scheduler FSM (state + round-robin pointer)
//   - onehot4 helper: 2-bit index to 4-bit one-hot vector
package noc_pkg;

  localparam int NUM_IN_PORTS = 4;
  localparam int ADDR_W       = 5;
  localparam int DATA_W       = 32;

  // Scheduler FSM encoding. The value 2'd3 is unused and falls back to IDLE.
  localparam logic [1:0] SCH_IDLE = 2'd0;
  localparam logic [1:0] SCH_LOAD = 2'd1;
  localparam logic [1:0] SCH_BUSY = 2'd2;

  // Debug view of the scheduler, so checkers can bind to internal state
  // without reaching into the hierarchy.
  typedef struct packed {
    logic [1:0] state;
    logic [1:0] rr_ptr;
  } sch_dbg_t;

  function automatic logic [NUM_IN_PORTS-1:0] onehot4(input logic [1:0] idx);
    logic [NUM_IN_PORTS-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/noc_input_rr_scheduler_rr_pick4.sv
// rr_pick4: combinational 4-way round-robin picker.
//   req  in  4  request vector, bit i = port i+1
//   ptr  in  2  highest-priority index for this pick
//   any  out 1  at least one request present
//   idx  out 2  first requesting index found searching ptr, ptr+1, ... mod 4
//               (0 when nothing is requesting)
module rr_pick4
  import noc_pkg::*;
(
  input  logic [NUM_IN_PORTS-1:0] req,
  input  logic [1:0]              ptr,
  output logic                    any,
  output logic [1:0]              idx
);

  logic [1:0] cand;

  // Walk the offsets from farthest to nearest so that the nearest
  // requester (smallest offset from ptr) is the last one written and wins.
  always_comb begin
    any  = |req;
    idx  = 2'd0;
    cand = 2'd0;
    for (int i = NUM_IN_PORTS - 1; i >= 0; i--) begin
      cand = ptr + 2'(i);
      if (req[cand]) begin
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/noc_input_rr_scheduler.sv
// noc_input_rr_scheduler: round-robin scheduler for the 4 input ports of a
// mesh router node. It grants one requesting input, strobes the node's
// single flit buffer to capture that input, then holds the buffer until
// the output stage reports delivery before arbitrating again.
//
// Ports:
//   clk        in   1  clock, all state updates on rising edge
//   rst        in   1  synchronous active-high reset
//   in_valid   in   4  request per input port (bit0 = port1 .. bit3 = port4)
//   out_done   in   1  1-cycle pulse: buffered flit accepted downstream
//   grant      out  4  registered one-hot grant, 0 when no grant
//   in_sel     out  2  buffer mux select of granted port, 0 when idle
//   load_en    out  1  buffer capture strobe (only in LOAD)
//   to_in_ack  out  4  one-hot ack to the granted input, coincident with load_en
//   busy       out  1  buffer holds an undelivered flit
//   stall_err  out  1  sticky: BUSY lasted TIMEOUT_CYCLES without out_done
//   dbg        out  4  debug view: FSM state and round-robin pointer
//
// Handshake: a requester raises in_valid and holds it (with its addr/data)
// stable until it sees its to_in_ack bit; the ack is the single-cycle LOAD
// strobe, so the transfer completes exactly in the cycle load_en is high.
// Downstream delivery is signalled back by a one-cycle out_done pulse,
// which is only honoured while the buffer is BUSY.
module noc_input_rr_scheduler
  import noc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN_PORTS-1:0] in_valid,
  input  logic                    out_done,
  output logic [NUM_IN_PORTS-1:0] grant,
  output logic [1:0]              in_sel,
  output logic                    load_en,
  output logic [NUM_IN_PORTS-1:0] to_in_ack,
  output logic                    busy,
  output logic                    stall_err,
  output sch_dbg_t                dbg
);

  // busy_cnt holds the number of completed BUSY cycles without delivery,
  // so it reads TIMEOUT_CYCLES-1 during the last permitted BUSY cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [1:0]       state;
  logic [1:0]       rr_ptr;
  logic [CNT_W-1:0] busy_cnt;

  logic             pick_any;
  logic [1:0]       pick_idx;

  rr_pick4 u_pick (
    .req (in_valid),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SCH_IDLE;
      rr_ptr    <= 2'd0;
      grant     <= '0;
      in_sel    <= 2'd0;
      busy_cnt  <= '0;
      stall_err <= 1'b0;
    end else begin
      case (state)
        SCH_IDLE: begin
          if (pick_any) begin
            grant  <= onehot4(pick_idx);
            in_sel <= pick_idx;
            state  <= SCH_LOAD;
          end
        end

        SCH_LOAD: begin
          busy_cnt <= '0;
          state    <= SCH_BUSY;
        end

        SCH_BUSY: begin
          if (out_done) begin
            // Pointer moves only on a completed transfer, just past the
            // port that was served, which bounds any waiter to 3 transfers.
            rr_ptr <= in_sel + 2'd1;
            grant  <= '0;
            in_sel <= 2'd0;
            state  <= SCH_IDLE;
          end else begin
            if (busy_cnt != CNT_MAX) begin
              busy_cnt <= busy_cnt + 1'b1;
            end
            // Flag only; the flit is kept and the FSM keeps waiting.
            if (busy_cnt == CNT_LAST) begin
              stall_err <= 1'b1;
            end
          end
        end

        default: begin
          state <= SCH_IDLE;
        end
      endcase
    end
  end

  // Strobes are pure decodes of the LOAD state so they can never appear
  // outside the single LOAD cycle.
  assign load_en   = (state == SCH_LOAD);
  assign to_in_ack = load_en ? grant : '0;
  assign busy      = (state == SCH_BUSY);

  assign dbg.state  = state;
  assign dbg.rr_ptr = rr_ptr;

endmodule
